// File: rtl/mux4_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter_if
// Bundles the request/data side and the granted/muxed output side of the
// four-way round-robin mux arbiter.
//   req      4       request per source: [0]=X [1]=Y [2]=Z [3]=W
//   X,Y,Z,W  DATA_W  source words
//   gnt      4       one-hot grant, 0 when idle
//   s1,s0    1       mux selects, {s1,s0} = granted index
//   M        DATA_W  registered mux output
//   valid    1       M holds a word transferred under grant
//   busy     1       arbiter is in GRANT state
// master : the requesting sources / sink side
// slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface mux4_rr_arbiter_if #(
    parameter int DATA_W = 3
);
    logic [3:0]        req;
    logic [DATA_W-1:0] X;
    logic [DATA_W-1:0] Y;
    logic [DATA_W-1:0] Z;
    logic [DATA_W-1:0] W;
    logic [3:0]        gnt;
    logic              s1;
    logic              s0;
    logic [DATA_W-1:0] M;
    logic              valid;
    logic              busy;

    modport master (
        output req, X, Y, Z, W,
        input  gnt, s1, s0, M, valid, busy
    );

    modport slave (
        input  req, X, Y, Z, W,
        output gnt, s1, s0, M, valid, busy
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
// Round-robin arbiter sharing one 4:1 DATA_W-bit mux channel among four
// requesters. The grant drives the internal 2x1-mux tree selects, and the
// selected word is registered onto M with a valid flag. Bursts are bounded
// to MAX_BURST cycles while another requester is waiting.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   mux4_rr_arbiter_if.slave (req, X..W in; gnt, s1, s0, M, valid, busy out)
// -----------------------------------------------------------------------------
module mux4_rr_arbiter #(
    parameter int DATA_W    = 3,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mux4_rr_arbiter_if.slave     bus
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state_r;
    logic [1:0]          ptr_r;
    logic [1:0]          owner_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [3:0]          gnt_r;
    logic                s1_r;
    logic                s0_r;
    logic                busy_r;
    logic [DATA_W-1:0]   m_r;
    logic                valid_r;

    logic [3:0]          others_s;
    logic                any_req_s;
    logic                any_other_s;
    logic                owner_req_s;
    logic [1:0]          idle_pick_s;
    logic [1:0]          next_pick_s;
    logic [DATA_W-1:0]   mux_s;

    // First asserted request searching base+1, base+2, ... wrapping modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] idx;
        logic [1:0] res;
        logic       found;
        res   = base;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = base + 2'(k);
            if (!found && r[idx]) begin
                res   = idx;
                found = 1'b1;
            end else begin
                res   = res;
                found = found;
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] one_hot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    function automatic logic [DATA_W-1:0] mux2(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic              sel);
        return sel ? b : a;
    endfunction

    // Arbitration decisions and the 2x1-mux tree driven by the registered selects.
    always_comb begin
        others_s    = bus.req & ~one_hot(owner_r);
        any_req_s   = |bus.req;
        any_other_s = |others_s;
        owner_req_s = bus.req[owner_r];
        idle_pick_s = rr_pick(bus.req, ptr_r);
        // Searching from the owner skips it; this serves both the release
        // case (owner not requesting) and the forced rotation.
        next_pick_s = rr_pick(others_s, owner_r);
        mux_s       = mux2(mux2(bus.X, bus.Y, s0_r), mux2(bus.Z, bus.W, s0_r), s1_r);
    end

    // Arbitration FSM with registered grant, selects and busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            ptr_r   <= 2'd3;
            owner_r <= 2'd0;
            cnt_r   <= '0;
            gnt_r   <= 4'b0000;
            s1_r    <= 1'b0;
            s0_r    <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        state_r <= GRANT;
                        owner_r <= idle_pick_s;
                        gnt_r   <= one_hot(idle_pick_s);
                        s1_r    <= idle_pick_s[1];
                        s0_r    <= idle_pick_s[0];
                        cnt_r   <= CNT_ONE;
                        busy_r  <= 1'b1;
                    end else begin
                        gnt_r   <= 4'b0000;
                        s1_r    <= 1'b0;
                        s0_r    <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!owner_req_s) begin
                        ptr_r <= owner_r;
                        if (any_other_s) begin
                            // Hand over directly, no idle cycle in between.
                            owner_r <= next_pick_s;
                            gnt_r   <= one_hot(next_pick_s);
                            s1_r    <= next_pick_s[1];
                            s0_r    <= next_pick_s[0];
                            cnt_r   <= CNT_ONE;
                        end else begin
                            state_r <= IDLE;
                            gnt_r   <= 4'b0000;
                            s1_r    <= 1'b0;
                            s0_r    <= 1'b0;
                            cnt_r   <= '0;
                            busy_r  <= 1'b0;
                        end
                    end else if (cnt_r == CNT_MAX && any_other_s) begin
                        ptr_r   <= owner_r;
                        owner_r <= next_pick_s;
                        gnt_r   <= one_hot(next_pick_s);
                        s1_r    <= next_pick_s[1];
                        s0_r    <= next_pick_s[0];
                        cnt_r   <= CNT_ONE;
                    end else if (cnt_r == CNT_MAX) begin
                        // Nobody else waiting: the owner simply starts a new burst.
                        cnt_r   <= CNT_ONE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    gnt_r   <= 4'b0000;
                    s1_r    <= 1'b0;
                    s0_r    <= 1'b0;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Output word register: loads only while the owner still requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_r     <= '0;
            valid_r <= 1'b0;
        end else if (state_r == GRANT && owner_req_s) begin
            m_r     <= mux_s;
            valid_r <= 1'b1;
        end else begin
            valid_r <= 1'b0;
        end
    end

    assign bus.gnt   = gnt_r;
    assign bus.s1    = s1_r;
    assign bus.s0    = s0_r;
    assign bus.busy  = busy_r;
    assign bus.M     = m_r;
    assign bus.valid = valid_r;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux4_rr_arbiter
// Directed testbench for mux4_rr_arbiter (DATA_W=3, MAX_BURST=4). Inputs are
// driven and outputs sampled 1 time unit after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mux4_rr_arbiter_if #(.DATA_W(3)) bus ();

    mux4_rr_arbiter #(.DATA_W(3), .MAX_BURST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 4'b0000;
        bus.X = 3'b000; bus.Y = 3'b000; bus.Z = 3'b000; bus.W = 3'b000;
        tick();
        tick();
        checks++;
        if ({bus.gnt, bus.s1, bus.s0, bus.M, bus.valid, bus.busy} !== 11'b0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b s=%b%b M=%b valid=%b busy=%b want all zero",
                     bus.gnt, bus.s1, bus.s0, bus.M, bus.valid, bus.busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        bus.Z = 3'b101;
        bus.req = 4'b0100;
        tick();
        checks++;
        if ({bus.gnt, bus.s1, bus.s0, bus.busy, bus.valid} !== 8'b0100_1010) begin
            errors++;
            $display("FAIL single_grant: got gnt=%b s=%b%b busy=%b valid=%b want gnt=0100 s=10 busy=1 valid=0",
                     bus.gnt, bus.s1, bus.s0, bus.busy, bus.valid);
        end
        tick();
        checks++;
        if ({bus.M, bus.valid} !== 4'b101_1) begin
            errors++;
            $display("FAIL single_data: got M=%b valid=%b want M=101 valid=1", bus.M, bus.valid);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] want;
        do_reset();
        bus.req = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            tick();
            want = 4'b0001 << ((c / 4) % 4);
            checks++;
            if (bus.gnt !== want || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL rotation_cyc%0d: got gnt=%b busy=%b want gnt=%b busy=1",
                         c, bus.gnt, bus.busy, want);
            end
        end
    endtask

    task automatic test_hold();
        do_reset();
        bus.W = 3'b110;
        bus.req = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (bus.gnt !== 4'b0001) begin
                errors++;
                $display("FAIL hold_cyc%0d: got gnt=%b want 0001", c, bus.gnt);
            end
        end
        bus.req = 4'b0000;
        tick();
        checks++;
        if ({bus.gnt, bus.valid, bus.busy, bus.s1, bus.s0} !== 8'b0) begin
            errors++;
            $display("FAIL hold_release: got gnt=%b valid=%b busy=%b s=%b%b want all zero",
                     bus.gnt, bus.valid, bus.busy, bus.s1, bus.s0);
        end
    endtask

    task automatic test_release_switch();
        do_reset();
        bus.Y = 3'b001;
        bus.W = 3'b011;
        bus.req = 4'b0010;
        tick();
        checks++;
        if (bus.gnt !== 4'b0010) begin
            errors++;
            $display("FAIL switch_owner_y: got gnt=%b want 0010", bus.gnt);
        end
        tick();
        checks++;
        if ({bus.M, bus.valid} !== 4'b001_1) begin
            errors++;
            $display("FAIL switch_data_y: got M=%b valid=%b want M=001 valid=1", bus.M, bus.valid);
        end
        bus.req = 4'b1000;
        tick();
        checks++;
        if ({bus.gnt, bus.s1, bus.s0, bus.valid} !== 7'b1000_11_0) begin
            errors++;
            $display("FAIL switch_to_w: got gnt=%b s=%b%b valid=%b want gnt=1000 s=11 valid=0",
                     bus.gnt, bus.s1, bus.s0, bus.valid);
        end
        tick();
        checks++;
        if ({bus.gnt, bus.M, bus.valid} !== 8'b1000_011_1) begin
            errors++;
            $display("FAIL switch_data_w: got gnt=%b M=%b valid=%b want gnt=1000 M=011 valid=1",
                     bus.gnt, bus.M, bus.valid);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        bus.Z = 3'b110;
        bus.req = 4'b0100;
        tick();
        tick();
        checks++;
        if ({bus.gnt, bus.M, bus.valid} !== 8'b0100_110_1) begin
            errors++;
            $display("FAIL midrst_pre: got gnt=%b M=%b valid=%b want gnt=0100 M=110 valid=1",
                     bus.gnt, bus.M, bus.valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.gnt, bus.M, bus.valid, bus.busy, bus.s1, bus.s0} !== 11'b0) begin
            errors++;
            $display("FAIL midrst_async: got gnt=%b M=%b valid=%b busy=%b s=%b%b want all zero",
                     bus.gnt, bus.M, bus.valid, bus.busy, bus.s1, bus.s0);
        end
        bus.req = 4'b1111;
        #1;
        rst = 1'b0;
        tick();
        checks++;
        if ({bus.gnt, bus.s1, bus.s0} !== 6'b0001_00) begin
            errors++;
            $display("FAIL midrst_restart: got gnt=%b s=%b%b want gnt=0001 s=00",
                     bus.gnt, bus.s1, bus.s0);
        end
    endtask

    task automatic test_alternate();
        logic [2:0] want;
        do_reset();
        bus.X = 3'b010;
        bus.Y = 3'b111;
        bus.req = 4'b0011;
        tick();
        for (int c = 0; c < 8; c++) begin
            tick();
            want = (c < 4) ? 3'b010 : 3'b111;
            checks++;
            if (bus.M !== want || bus.valid !== 1'b1) begin
                errors++;
                $display("FAIL alternate_cyc%0d: got M=%b valid=%b want M=%b valid=1",
                         c, bus.M, bus.valid, want);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single();
        test_rotation();
        test_hold();
        test_release_switch();
        test_reset_mid_burst();
        test_alternate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
